// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size encodings common with the
// data memory, FSM states, and default memory geometry.
package load_store_unit_pkg;

    localparam int          BUS_WIDTH     = 32;
    localparam int          DEF_MEM_BYTES = 64;
    localparam logic [31:0] DEF_IO_ADDR   = 32'd64;

    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] WORD      = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        SPLIT  = 2'b10
    } lsu_state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            BYTE:      size_bytes = 3'd1;
            HALF_WORD: size_bytes = 3'd2;
            WORD:      size_bytes = 3'd4;
            default:   size_bytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response bus and memory-side port of the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_sx;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wr, req_size, req_sx, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_wr, req_size, req_sx, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface load_store_unit_mem_if;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_wr_en;
    logic [1:0]  mem_size;
    logic        mem_sz_ex;
    logic [31:0] mem_data_out;

    modport master (
        output mem_address, mem_data_in, mem_wr_en, mem_size, mem_sz_ex,
        input  mem_data_out
    );
    modport slave (
        input  mem_address, mem_data_in, mem_wr_en, mem_size, mem_sz_ex,
        output mem_data_out
    );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Combinational sign/zero extender applied to a little-endian assembled load value.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [1:0]           i_size,
    input  logic                 i_sx,
    input  logic [BUS_WIDTH-1:0] i_raw,
    output logic [BUS_WIDTH-1:0] o_ext
);

    // Extend from the top bit of the accessed width
    always_comb begin
        o_ext = i_raw;
        case (i_size)
            BYTE:      o_ext = {{24{i_sx & i_raw[7]}}, i_raw[7:0]};
            HALF_WORD: o_ext = {{16{i_sx & i_raw[15]}}, i_raw[15:0]};
            default:   o_ext = i_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller: classifies requests, splits misaligned
// accesses into bytes, decodes the memory-mapped output register.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int          MEM_BYTES = DEF_MEM_BYTES,
    parameter logic [31:0] IO_ADDR   = DEF_IO_ADDR
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    load_store_unit_if.slave      req_if,
    load_store_unit_mem_if.master mem_if,
    output logic [BUS_WIDTH-1:0]  o_io_out,
    output logic                  o_io_wr_strobe
);

    localparam logic [32:0] LP_MEM_LIMIT = 33'(MEM_BYTES);

    lsu_state_e  r_state;
    logic [1:0]  r_k;
    logic [1:0]  r_size;
    logic        r_wr;
    logic        r_sx;
    logic        r_is_io;
    logic        r_is_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_asm;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic [31:0] r_io_out;
    logic        r_io_wr_strobe;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_data_in;
    logic        r_mem_wr_en;
    logic [1:0]  r_mem_size;
    logic        r_mem_sz_ex;

    logic        w_accept;
    logic [2:0]  w_nbytes;
    logic [32:0] w_last;
    logic        w_is_io;
    logic        w_is_err;
    logic        w_split;
    logic [1:0]  w_k_last;
    logic [1:0]  w_k_next;
    logic [7:0]  w_wdata_next_byte;
    logic [31:0] w_asm_next;
    logic [31:0] w_ext;

    // Request classification; the 33-bit end address catches wrap past 2^32
    always_comb begin
        w_accept = req_if.req_valid && r_req_ready;
        w_nbytes = size_bytes(req_if.req_size);
        w_last   = {1'b0, req_if.req_addr} + {30'd0, w_nbytes} - 33'd1;
        w_is_io  = (req_if.req_addr == IO_ADDR);
        w_is_err = (req_if.req_size == 2'b11) ||
                   (w_is_io && (req_if.req_size != WORD)) ||
                   (!w_is_io && (w_last >= LP_MEM_LIMIT));
        w_split  = !w_is_err && !w_is_io &&
                   (((req_if.req_size == HALF_WORD) && req_if.req_addr[0]) ||
                    ((req_if.req_size == WORD) && (req_if.req_addr[1:0] != 2'b00)));
    end

    // Split-access byte sequencing and little-endian assembly
    always_comb begin
        w_k_last          = (r_size == HALF_WORD) ? 2'd1 : 2'd3;
        w_k_next          = r_k + 2'd1;
        w_wdata_next_byte = r_wdata[{w_k_next, 3'b000} +: 8];
        w_asm_next        = r_asm;
        w_asm_next[{r_k, 3'b000} +: 8] = mem_if.mem_data_out[7:0];
    end

    load_extend u_load_extend (
        .i_size (r_size),
        .i_sx   (r_sx),
        .i_raw  (w_asm_next),
        .o_ext  (w_ext)
    );

    // Main FSM with all outputs registered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_k            <= 2'd0;
            r_size         <= WORD;
            r_wr           <= 1'b0;
            r_sx           <= 1'b0;
            r_is_io        <= 1'b0;
            r_is_err       <= 1'b0;
            r_addr         <= 32'd0;
            r_wdata        <= 32'd0;
            r_asm          <= 32'd0;
            r_req_ready    <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= 32'd0;
            r_resp_err     <= 1'b0;
            r_io_out       <= 32'd0;
            r_io_wr_strobe <= 1'b0;
            r_mem_address  <= 32'd0;
            r_mem_data_in  <= 32'd0;
            r_mem_wr_en    <= 1'b0;
            r_mem_size     <= WORD;
            r_mem_sz_ex    <= 1'b0;
        end else begin
            r_resp_valid   <= 1'b0;
            r_io_wr_strobe <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready   <= 1'b0;
                        r_wr          <= req_if.req_wr;
                        r_size        <= req_if.req_size;
                        r_sx          <= req_if.req_sx;
                        r_addr        <= req_if.req_addr;
                        r_wdata       <= req_if.req_wdata;
                        r_is_io       <= w_is_io;
                        r_is_err      <= w_is_err;
                        r_asm         <= 32'd0;
                        r_k           <= 2'd0;
                        r_mem_address <= req_if.req_addr;
                        r_mem_size    <= w_split ? BYTE : req_if.req_size;
                        r_mem_sz_ex   <= w_split ? 1'b0 : req_if.req_sx;
                        r_mem_data_in <= w_split ? {24'd0, req_if.req_wdata[7:0]} : req_if.req_wdata;
                        r_mem_wr_en   <= req_if.req_wr && !w_is_err && !w_is_io;
                        r_state       <= w_split ? SPLIT : ACCESS;
                    end else begin
                        r_req_ready   <= 1'b1;
                    end
                end
                ACCESS: begin
                    r_state      <= IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b1;
                    r_mem_wr_en  <= 1'b0;
                    if (r_is_err) begin
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= 32'd0;
                    end else if (r_is_io) begin
                        r_resp_err   <= 1'b0;
                        if (r_wr) begin
                            r_io_out       <= r_wdata;
                            r_io_wr_strobe <= 1'b1;
                            r_resp_rdata   <= 32'd0;
                        end else begin
                            r_resp_rdata   <= r_io_out;
                        end
                    end else begin
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_wr ? 32'd0 : mem_if.mem_data_out;
                    end
                end
                SPLIT: begin
                    r_asm <= w_asm_next;
                    if (r_k == w_k_last) begin
                        r_state      <= IDLE;
                        r_req_ready  <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_wr ? 32'd0 : w_ext;
                        r_mem_wr_en  <= 1'b0;
                    end else begin
                        r_k           <= w_k_next;
                        r_mem_address <= r_addr + {30'd0, w_k_next};
                        r_mem_data_in <= {24'd0, w_wdata_next_byte};
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign req_if.req_ready  = r_req_ready;
    assign req_if.resp_valid = r_resp_valid;
    assign req_if.resp_rdata = r_resp_rdata;
    assign req_if.resp_err   = r_resp_err;
    assign mem_if.mem_address = r_mem_address;
    assign mem_if.mem_data_in = r_mem_data_in;
    assign mem_if.mem_wr_en   = r_mem_wr_en;
    assign mem_if.mem_size    = r_mem_size;
    assign mem_if.mem_sz_ex   = r_mem_sz_ex;
    assign o_io_out       = r_io_out;
    assign o_io_wr_strobe = r_io_wr_strobe;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural byte memory
// (combinational read, negedge write).
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_mem = 1'b1;
    logic [31:0] io_out;
    logic        io_wr_strobe;
    int          tests_run = 0;
    int          fails = 0;
    logic [7:0]  mem [0:63];

    load_store_unit_if     req_if ();
    load_store_unit_mem_if mem_if ();

    load_store_unit #(.MEM_BYTES(64), .IO_ADDR(32'd64)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .req_if         (req_if),
        .mem_if         (mem_if),
        .o_io_out       (io_out),
        .o_io_wr_strobe (io_wr_strobe)
    );

    always #5 clk = ~clk;

    // Memory read model: little-endian bytes, extension by size/sz_ex
    always_comb begin
        logic [31:0] raw;
        raw = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if ((mem_if.mem_address + 32'(i)) < 32'd64)
                raw[8*i +: 8] = mem[6'(mem_if.mem_address + 32'(i))];
        end
        case (mem_if.mem_size)
            2'b00:   mem_if.mem_data_out = {{24{mem_if.mem_sz_ex & raw[7]}}, raw[7:0]};
            2'b01:   mem_if.mem_data_out = {{16{mem_if.mem_sz_ex & raw[15]}}, raw[15:0]};
            default: mem_if.mem_data_out = raw;
        endcase
    end

    // Memory write model on negedge; preloaded while init_mem is set
    always @(negedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            mem[0] <= 8'h93; mem[1] <= 8'h81; mem[2] <= 8'h71; mem[3] <= 8'h00;
            mem[4] <= 8'h23; mem[5] <= 8'h20; mem[6] <= 8'h30; mem[7] <= 8'h04;
        end else if (mem_if.mem_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if ((i < int'(size_bytes(mem_if.mem_size))) && ((mem_if.mem_address + 32'(i)) < 32'd64))
                    mem[6'(mem_if.mem_address + 32'(i))] <= mem_if.mem_data_in[8*i +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request in the current cycle and follow it to its response
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sx,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int wr_cnt, output int strb_cnt, output int rdy_low,
                          output logic rdy_resp, output logic [31:0] io_resp,
                          output logic [3:0][31:0] alog, output int nonbyte);
        req_if.req_valid = 1'b1;
        req_if.req_wr    = wr;
        req_if.req_size  = sz;
        req_if.req_sx    = sx;
        req_if.req_addr  = addr;
        req_if.req_wdata = wd;
        tick();
        req_if.req_valid = 1'b0;
        lat = 1; wr_cnt = 0; strb_cnt = 0; rdy_low = 0; nonbyte = 0;
        alog = '0;
        while (!req_if.resp_valid && lat < 20) begin
            if (mem_if.mem_wr_en) wr_cnt++;
            if (io_wr_strobe) strb_cnt++;
            if (!req_if.req_ready) rdy_low++;
            if (mem_if.mem_size != BYTE) nonbyte++;
            if (lat <= 4) alog[lat-1] = mem_if.mem_address;
            tick();
            lat++;
        end
        if (mem_if.mem_wr_en) wr_cnt++;
        if (io_wr_strobe) strb_cnt++;
        rd       = req_if.resp_rdata;
        er       = req_if.resp_err;
        rdy_resp = req_if.req_ready;
        io_resp  = io_out;
    endtask

    int               lat, wr_cnt, strb_cnt, rdy_low, nonbyte, rv_cnt;
    logic [31:0]      rd, io_resp;
    logic             er, rdy_resp;
    logic [3:0][31:0] alog;

    initial begin
        req_if.req_valid = 1'b0;
        req_if.req_wr    = 1'b0;
        req_if.req_size  = 2'b00;
        req_if.req_sx    = 1'b0;
        req_if.req_addr  = 32'd0;
        req_if.req_wdata = 32'd0;

        tick();
        chk("rst_ready",      32'(req_if.req_ready),  32'd0);
        chk("rst_resp_valid", 32'(req_if.resp_valid), 32'd0);
        chk("rst_resp_rdata", req_if.resp_rdata,      32'd0);
        chk("rst_resp_err",   32'(req_if.resp_err),   32'd0);
        chk("rst_io_out",     io_out,                 32'd0);
        chk("rst_io_strobe",  32'(io_wr_strobe),      32'd0);
        chk("rst_mem_wr_en",  32'(mem_if.mem_wr_en),  32'd0);
        chk("rst_mem_addr",   mem_if.mem_address,     32'd0);
        chk("rst_mem_size",   32'(mem_if.mem_size),   32'd2);
        chk("rst_mem_sz_ex",  32'(mem_if.mem_sz_ex),  32'd0);
        chk("rst_mem_din",    mem_if.mem_data_in,     32'd0);
        tick();
        init_mem = 1'b0;
        rst      = 1'b0;
        tick();
        chk("ready_after_rst", 32'(req_if.req_ready), 32'd1);

        do_req(1'b0, BYTE, 1'b1, 32'd0, 32'd0, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("lb_sx_lat",   32'(lat), 32'd2);
        chk("lb_sx_data",  rd,       32'hFFFFFF93);
        chk("lb_sx_ready", 32'(rdy_resp), 32'd1);

        do_req(1'b0, BYTE, 1'b0, 32'd0, 32'd0, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("lb_zx_lat",  32'(lat), 32'd2);
        chk("lb_zx_data", rd,       32'h00000093);

        do_req(1'b0, HALF_WORD, 1'b1, 32'd1, 32'd0, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("lh_mis_lat",     32'(lat), 32'd3);
        chk("lh_mis_data",    rd,       32'h00007181);
        chk("lh_mis_addr0",   alog[0],  32'd1);
        chk("lh_mis_addr1",   alog[1],  32'd2);
        chk("lh_mis_nonbyte", 32'(nonbyte), 32'd0);

        do_req(1'b0, WORD, 1'b0, 32'd1, 32'd0, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("lw_mis_lat",     32'(lat), 32'd5);
        chk("lw_mis_data",    rd,       32'h23007181);
        chk("lw_mis_rdy_low", 32'(rdy_low), 32'd4);
        chk("lw_mis_rdy_rsp", 32'(rdy_resp), 32'd1);

        do_req(1'b1, WORD, 1'b0, 32'd16, 32'hDEADBEEF, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("sw16_lat",   32'(lat),    32'd2);
        chk("sw16_wr",    32'(wr_cnt), 32'd1);
        chk("sw16_rdata", rd,          32'd0);

        do_req(1'b0, HALF_WORD, 1'b1, 32'd18, 32'd0, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("lh18_lat",  32'(lat), 32'd2);
        chk("lh18_data", rd,       32'hFFFFDEAD);

        do_req(1'b1, WORD, 1'b0, 32'd17, 32'hDEADBEEF, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("sw17_lat", 32'(lat),    32'd5);
        chk("sw17_wr",  32'(wr_cnt), 32'd4);

        do_req(1'b0, WORD, 1'b0, 32'd17, 32'd0, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("lw17_lat",  32'(lat), 32'd5);
        chk("lw17_data", rd,       32'hDEADBEEF);

        do_req(1'b1, WORD, 1'b0, 32'd64, 32'd7, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("io_st_lat",    32'(lat),      32'd2);
        chk("io_st_wr",     32'(wr_cnt),   32'd0);
        chk("io_st_strobe", 32'(strb_cnt), 32'd1);
        chk("io_st_out",    io_resp,       32'd7);
        chk("io_st_err",    32'(er),       32'd0);
        tick();
        chk("io_strobe_end", 32'(io_wr_strobe), 32'd0);

        do_req(1'b0, WORD, 1'b0, 32'd64, 32'd0, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("io_ld_lat",    32'(lat),      32'd2);
        chk("io_ld_data",   rd,            32'd7);
        chk("io_ld_strobe", 32'(strb_cnt), 32'd0);

        do_req(1'b0, WORD, 1'b0, 32'd62, 32'd0, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("err_lw62_lat", 32'(lat), 32'd2);
        chk("err_lw62_err", 32'(er),  32'd1);
        chk("err_lw62_rd",  rd,       32'd0);
        chk("err_lw62_wr",  32'(wr_cnt), 32'd0);

        do_req(1'b0, HALF_WORD, 1'b0, 32'd64, 32'd0, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("err_lh64_err", 32'(er), 32'd1);
        chk("err_lh64_rd",  rd,      32'd0);
        chk("err_lh64_wr",  32'(wr_cnt), 32'd0);

        do_req(1'b0, 2'b11, 1'b0, 32'd0, 32'd0, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("err_sz3_err", 32'(er), 32'd1);
        chk("err_sz3_rd",  rd,      32'd0);
        chk("err_sz3_wr",  32'(wr_cnt), 32'd0);

        do_req(1'b1, WORD, 1'b0, 32'd62, 32'hCAFEF00D, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("err_sw62_err", 32'(er),     32'd1);
        chk("err_sw62_wr",  32'(wr_cnt), 32'd0);
        chk("err_sw62_mem", 32'(mem[62]), 32'd0);

        // Reset while byte 2 of a split store is on the memory port
        req_if.req_valid = 1'b1;
        req_if.req_wr    = 1'b1;
        req_if.req_size  = WORD;
        req_if.req_sx    = 1'b0;
        req_if.req_addr  = 32'd17;
        req_if.req_wdata = 32'h11223344;
        tick();
        req_if.req_valid = 1'b0;
        tick();
        tick();
        chk("abort_k2_addr", mem_if.mem_address, 32'd19);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready_rst", 32'(req_if.req_ready), 32'd0);
        chk("abort_wr_en",     32'(mem_if.mem_wr_en), 32'd0);
        rv_cnt = 0;
        if (req_if.resp_valid) rv_cnt++;
        tick();
        chk("abort_ready_after", 32'(req_if.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (req_if.resp_valid) rv_cnt++;
            tick();
        end
        chk("abort_no_resp", 32'(rv_cnt), 32'd0);
        chk("abort_mem17",   32'(mem[17]), 32'h44);
        chk("abort_mem19",   32'(mem[19]), 32'h22);
        chk("abort_mem20",   32'(mem[20]), 32'hDE);
        chk("abort_io_out",  io_out,       32'd0);

        do_req(1'b0, WORD, 1'b0, 32'd16, 32'd0, lat, rd, er, wr_cnt, strb_cnt, rdy_low, rdy_resp, io_resp, alog, nonbyte);
        chk("post_abort_lat",  32'(lat), 32'd2);
        chk("post_abort_data", rd,       32'h223344EF);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
